// File: rtl/knockout_trigger_multi.sv
// Pipelined multi-channel instruction-match trigger for the knockout debug path.
// Define KNOCKOUT_TRIG_MASK_EN to honour trig_mask; otherwise compare is exact.
module knockout_trigger_multi #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  parameter int NCH   = 2,
  parameter int CNT_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] inst,
  input  logic [NCH-1:0]       inst_valid,
  input  logic [WIDTH-1:0]     trig_val,
  input  logic [WIDTH-1:0]     trig_mask,
  input  logic [CNT_W-1:0]     trig_thresh,
  input  logic                 arm,
  input  logic                 clear,
  output logic                 armed,
  output logic                 trig,
  output logic                 trig_pulse,
  output logic [CH_W-1:0]      trig_ch,
  output logic [CNT_W-1:0]     match_cnt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int NGRP   = (NCHUNK + 3) / 4;
  localparam int PC_W   = 4;
  localparam int SUM_W  = CNT_W + PC_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FIRED
  } state_t;

  logic [NCH-1:0][NCHUNK-1:0] eq1_d;
  logic [NCH-1:0][NCHUNK-1:0] eq1;
  logic [NCH-1:0][NGRP-1:0]   eq2_d;
  logic [NCH-1:0][NGRP-1:0]   eq2;
  logic [NCH-1:0]             v1;
  logic [NCH-1:0]             v2;
  logic [NCH-1:0]             hit;
  logic [4*NGRP-1:0]          pad;
  logic [CHUNK-1:0]           ic;
  logic [CHUNK-1:0]           tc;

`ifndef KNOCKOUT_TRIG_MASK_EN
  logic unused_mask;
  assign unused_mask = ^trig_mask;
`endif

  always_comb begin
    eq1_d = '0;
    ic    = '0;
    tc    = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NCHUNK; k++) begin
        ic = inst[c*WIDTH+k*CHUNK +: CHUNK];
        tc = trig_val[k*CHUNK +: CHUNK];
`ifdef KNOCKOUT_TRIG_MASK_EN
        eq1_d[c][k] =
          ~|((ic ^ tc) & trig_mask[k*CHUNK +: CHUNK]);
`else
        eq1_d[c][k] = (ic == tc);
`endif
      end
    end
  end

  // Last group is padded with ones so a partial group reduces cleanly.
  always_comb begin
    eq2_d = '0;
    pad   = '1;
    for (int c = 0; c < NCH; c++) begin
      pad = '1;
      pad[NCHUNK-1:0] = eq1[c];
      for (int g = 0; g < NGRP; g++)
        eq2_d[c][g] = &pad[g*4 +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq1 <= '0;
      v1  <= '0;
      eq2 <= '0;
      v2  <= '0;
    end else begin
      eq1 <= eq1_d;
      v1  <= inst_valid;
      eq2 <= eq2_d;
      v2  <= v1;
    end
  end

  always_comb begin
    hit = '0;
    for (int c = 0; c < NCH; c++)
      hit[c] = v2[c] & (&eq2[c]);
  end

  logic [PC_W-1:0]  n_hit;
  logic [CH_W-1:0]  lo_ch;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] sum_sat;

  always_comb begin
    n_hit = '0;
    lo_ch = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        n_hit = n_hit + PC_W'(1);
        lo_ch = CH_W'(c);
      end
    end
    sum     = SUM_W'(match_cnt) + SUM_W'(n_hit);
    sum_sat = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
  end

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] thr_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CH_W-1:0]  ch_d;
  logic             pulse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = match_cnt;
    thr_d   = thr_q;
    ch_d    = trig_ch;
    pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm && !clear) begin
          state_d = S_ARMED;
          cnt_d   = '0;
          thr_d   = (trig_thresh == '0) ? CNT_W'(1)
                                        : trig_thresh;
        end
      end
      S_ARMED: begin
        if (clear) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = sum_sat;
          if (sum_sat >= thr_q) begin
            state_d = S_FIRED;
            ch_d    = lo_ch;
            pulse_d = 1'b1;
          end
        end
      end
      S_FIRED: begin
        if (clear) state_d = S_IDLE;
        else       cnt_d   = sum_sat;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      match_cnt  <= '0;
      thr_q      <= '0;
      trig_ch    <= '0;
      trig_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_cnt  <= cnt_d;
      thr_q      <= thr_d;
      trig_ch    <= ch_d;
      trig_pulse <= pulse_d;
    end
  end

  assign armed = (state_q == S_ARMED);
  assign trig  = (state_q == S_FIRED);

endmodule

// File: tb/tb_knockout_trigger_multi.sv
// Directed vector bench for knockout_trigger_multi (default parameters).
// Expected outputs are packed {armed,trig,pulse,cnt[7:0],ch}.
module tb_knockout_trigger_multi;

  localparam logic [31:0] T  = 32'h00A0_2023;
  localparam logic [31:0] FM = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [63:0] inst;
  logic [1:0]  inst_valid;
  logic [31:0] trig_val;
  logic [31:0] trig_mask;
  logic [7:0]  trig_thresh;
  logic        arm;
  logic        clear;
  logic        armed;
  logic        trig;
  logic        trig_pulse;
  logic [0:0]  trig_ch;
  logic [7:0]  match_cnt;

  knockout_trigger_multi dut (
    .clk(clk),
    .rst(rst),
    .inst(inst),
    .inst_valid(inst_valid),
    .trig_val(trig_val),
    .trig_mask(trig_mask),
    .trig_thresh(trig_thresh),
    .arm(arm),
    .clear(clear),
    .armed(armed),
    .trig(trig),
    .trig_pulse(trig_pulse),
    .trig_ch(trig_ch),
    .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tv;
    logic [31:0] tm;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  vld;
    logic        a;
    logic        c;
    logic [7:0]  thr;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [11:0] got();
    return {armed, trig, trig_pulse, match_cnt, trig_ch};
  endfunction

  task automatic add(
    input logic [31:0] tv, tm, i0, i1,
    input logic [1:0]  vld,
    input logic        a, c,
    input logic [7:0]  thr,
    input logic        ea, et, ep,
    input logic [7:0]  ec,
    input logic        ech
  );
    vec_t v;
    v.tv  = tv;
    v.tm  = tm;
    v.i0  = i0;
    v.i1  = i1;
    v.vld = vld;
    v.a   = a;
    v.c   = c;
    v.thr = thr;
    v.exp = {ea, et, ep, ec, ech};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name,
                     input logic [11:0] g,
                     input logic [11:0] e);
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s got %h need %h", name, g, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    inst       = '0;
    inst_valid = '0;
    arm        = 1'b0;
    clear      = 1'b0;
  endtask

  int pulses;

  initial begin
    rst         = 1'b1;
    trig_val    = T;
    trig_mask   = FM;
    trig_thresh = 8'd1;
    idle_in();
    inst        = {T, T};
    inst_valid  = 2'b11;
    step();
    step();
    chk("reset_state", got(), 12'h000);
    idle_in();
    rst = 1'b0;
    step();

    // exact match, thr 1
    add(T, FM, T, 0, 2'b00, 1, 0, 1,  1, 0, 0, 0, 0);
    add(T, FM, T, 0, 2'b01, 0, 0, 1,  1, 0, 0, 0, 0);
    add(T, FM, 0, 0, 2'b00, 0, 0, 1,  1, 0, 0, 0, 0);
    add(T, FM, 0, 0, 2'b00, 0, 0, 1,  0, 1, 1, 1, 0);
    add(T, FM, 0, 0, 2'b00, 0, 0, 1,  0, 1, 0, 1, 0);
    add(T, FM, 0, 0, 2'b00, 0, 1, 1,  0, 0, 0, 1, 0);
    // threshold 3, two channels
    add(T, FM, 0, 0, 2'b00, 1, 0, 3,  1, 0, 0, 0, 0);
    add(T, FM, T, T, 2'b11, 0, 0, 3,  1, 0, 0, 0, 0);
    add(T, FM, 0, 0, 2'b00, 0, 0, 3,  1, 0, 0, 0, 0);
    add(T, FM, 0, T, 2'b10, 0, 0, 3,  1, 0, 0, 2, 0);
    add(T, FM, 0, 0, 2'b00, 0, 0, 3,  1, 0, 0, 2, 0);
    add(T, FM, 0, 0, 2'b00, 0, 0, 3,  0, 1, 1, 3, 1);
    add(T, FM, 0, 0, 2'b00, 0, 1, 3,  0, 0, 0, 3, 1);
    // near miss and unqualified match
    add(T, FM, 0, 0, 2'b00, 1, 0, 1,  1, 0, 0, 0, 1);
    add(T, FM, 32'h10A0_2023, T, 2'b01, 0, 0, 1,
        1, 0, 0, 0, 1);
    add(T, FM, 0, 0, 2'b00, 0, 0, 1,  1, 0, 0, 0, 1);
    add(T, FM, 0, 0, 2'b00, 0, 0, 1,  1, 0, 0, 0, 1);
    add(T, FM, 0, 0, 2'b00, 0, 0, 1,  1, 0, 0, 0, 1);
    add(T, FM, 0, 0, 2'b00, 0, 1, 1,  0, 0, 0, 0, 1);
    // masked compare
    add(32'h23, 32'h7F, 0, 0, 2'b00, 1, 0, 1,
        1, 0, 0, 0, 1);
    add(32'h23, 32'h7F, 32'hFFFF_FFA3, 0, 2'b01, 0, 0, 1,
        1, 0, 0, 0, 1);
    add(32'h23, 32'h7F, 0, 0, 2'b00, 0, 0, 1,
        1, 0, 0, 0, 1);
`ifdef KNOCKOUT_TRIG_MASK_EN
    add(32'h23, 32'h7F, 0, 0, 2'b00, 0, 0, 1,
        0, 1, 1, 1, 0);
    add(32'h23, 32'h7F, 0, 0, 2'b00, 0, 1, 1,
        0, 0, 0, 1, 0);
    add(T, FM, T, 0, 2'b01, 0, 0, 1,  0, 0, 0, 1, 0);
    add(T, FM, 0, 0, 2'b00, 1, 0, 1,  1, 0, 0, 0, 0);
`else
    add(32'h23, 32'h7F, 0, 0, 2'b00, 0, 0, 1,
        1, 0, 0, 0, 1);
    add(32'h23, 32'h7F, 0, 0, 2'b00, 0, 1, 1,
        0, 0, 0, 0, 1);
    add(T, FM, T, 0, 2'b01, 0, 0, 1,  0, 0, 0, 0, 1);
    add(T, FM, 0, 0, 2'b00, 1, 0, 1,  1, 0, 0, 0, 1);
`endif
    // word seen one cycle before arm still counts
    add(T, FM, 0, 0, 2'b00, 0, 0, 1,  0, 1, 1, 1, 0);
    add(T, FM, 0, 0, 2'b00, 0, 1, 1,  0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      trig_val    = vecs[i].tv;
      trig_mask   = vecs[i].tm;
      inst        = {vecs[i].i1, vecs[i].i0};
      inst_valid  = vecs[i].vld;
      arm         = vecs[i].a;
      clear       = vecs[i].c;
      trig_thresh = vecs[i].thr;
      step();
      chk($sformatf("row%0d", i), got(), vecs[i].exp);
    end
    idle_in();
    trig_val  = T;
    trig_mask = FM;

    // reset one cycle after a matching word
    arm         = 1'b1;
    trig_thresh = 8'd1;
    step();
    arm        = 1'b0;
    inst       = {32'h0, T};
    inst_valid = 2'b01;
    step();
    idle_in();
    rst = 1'b1;
    #1;
    chk("rst_async", got(), 12'h000);
    #2;
    rst = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("rst_rearm", got(), 12'h800);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_nofire%0d", i), got(), 12'h800);
    end

    // arm and clear together
    clear = 1'b1;
    step();
    arm = 1'b1;
    step();
    chk("arm_clear", got(), 12'h000);
    idle_in();
    step();
    chk("arm_clear_hold", got(), 12'h000);

    // saturation: 300 hits against threshold 255
    arm         = 1'b1;
    trig_thresh = 8'd255;
    step();
    arm        = 1'b0;
    inst       = {T, T};
    inst_valid = 2'b11;
    pulses     = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (trig_pulse) pulses++;
    end
    inst_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      if (trig_pulse) pulses++;
    end
    chk("sat_state", got(), {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0});
    chk("sat_pulses", 12'(pulses), 12'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
